// File: rtl/util_fifo_sync.sv
// Single-clock FIFO with optional first-word-fall-through output stage,
// registered status flags and one-cycle ack/overflow/underflow pulses.
module util_fifo_sync #(
    parameter int FIFO_DEPTH          = 256,
    parameter int BYTE_WIDTH          = 1,
    parameter int COUNT_WIDTH         = 9,
    parameter int FWFT                = 1,
    parameter int ACK_ENA             = 1,
    parameter int DATA_ZERO           = 0,
    parameter int ALMOST_FULL_THRESH  = FIFO_DEPTH - 4,
    parameter int ALMOST_EMPTY_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [8*BYTE_WIDTH-1:0]  wr_data,
    output logic                     wr_ack,
    output logic                     wr_full,
    output logic                     wr_almost_full,
    output logic                     wr_overflow,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [8*BYTE_WIDTH-1:0]  rd_data,
    output logic                     rd_empty,
    output logic                     rd_almost_empty,
    output logic                     rd_underflow,
    output logic [COUNT_WIDTH-1:0]   data_count
);

    localparam int W   = 8 * BYTE_WIDTH;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam bit FW  = (FWFT != 0);
    localparam bit ACK = (ACK_ENA != 0);
    localparam bit DZ  = (DATA_ZERO != 0);

    logic [W-1:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [W-1:0]           out_data;
    logic [COUNT_WIDTH-1:0] count_next;
    logic [COUNT_WIDTH-1:0] mem_count;
    logic                   readable;
    logic                   wr_acc;
    logic                   rd_acc;
    logic                   out_load;
    logic                   valid_next;

    // In FWFT mode the output register holds the head word, so data_count
    // includes it while the RAM holds data_count - rd_valid words.
    always_comb begin
        readable   = FW ? rd_valid : !rd_empty;
        wr_acc     = wr_en && !wr_full;
        rd_acc     = rd_en && readable;
        mem_count  = FW ? (data_count - COUNT_WIDTH'(rd_valid)) : data_count;
        out_load   = FW ? ((!rd_valid || rd_acc) && (mem_count != '0)) : rd_acc;
        valid_next = FW ? (out_load || (rd_valid && !rd_acc)) : out_load;
        count_next = data_count;
        if (wr_acc && !rd_acc) begin
            count_next = data_count + COUNT_WIDTH'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = data_count - COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            out_data        <= '0;
            data_count      <= '0;
            rd_valid        <= 1'b0;
            wr_ack          <= 1'b0;
            wr_overflow     <= 1'b0;
            rd_underflow    <= 1'b0;
            wr_full         <= 1'b0;
            wr_almost_full  <= (ALMOST_FULL_THRESH <= 0);
            rd_empty        <= 1'b1;
            rd_almost_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (out_load) begin
                rd_ptr   <= rd_ptr + AW'(1);
                out_data <= mem[rd_ptr];
            end
            data_count      <= count_next;
            rd_valid        <= valid_next;
            wr_ack          <= ACK && wr_acc;
            wr_overflow     <= wr_en && wr_full;
            rd_underflow    <= rd_en && !readable;
            wr_full         <= (count_next == COUNT_WIDTH'(FIFO_DEPTH));
            wr_almost_full  <= (count_next >= COUNT_WIDTH'(ALMOST_FULL_THRESH));
            rd_almost_empty <= (count_next <= COUNT_WIDTH'(ALMOST_EMPTY_THRESH));
            rd_empty        <= FW ? !valid_next : (count_next == '0);
        end
    end

    assign rd_data = (DZ && !rd_valid) ? '0 : out_data;

endmodule

// File: tb/tb_util_fifo_sync.sv
// Randomised scoreboard bench for util_fifo_sync: an FWFT lane and a standard
// read lane (with DATA_ZERO, no ack) share one stimulus stream.
`timescale 1ns/1ps
module tb_util_fifo_sync;

    localparam int DEPTH = 16;
    localparam int AFT   = 12;
    localparam int AET   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wr_data = '0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int lane_id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h at %0t", name, lane_id, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int FW  = (g == 0) ? 1 : 0;
        localparam int DZ  = g;
        localparam int ACK = 1 - g;

        logic       wr_ack, wr_full, wr_almost_full, wr_overflow;
        logic       rd_valid, rd_empty, rd_almost_empty, rd_underflow;
        logic [7:0] rd_data;
        logic [4:0] data_count;

        util_fifo_sync #(
            .FIFO_DEPTH(DEPTH), .BYTE_WIDTH(1), .COUNT_WIDTH(5), .FWFT(FW),
            .ACK_ENA(ACK), .DATA_ZERO(DZ),
            .ALMOST_FULL_THRESH(AFT), .ALMOST_EMPTY_THRESH(AET)
        ) dut (
            .clk(clk), .rst(rst),
            .wr_en(wr_en), .wr_data(wr_data), .wr_ack(wr_ack), .wr_full(wr_full),
            .wr_almost_full(wr_almost_full), .wr_overflow(wr_overflow),
            .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_empty(rd_empty),
            .rd_almost_empty(rd_almost_empty), .rd_underflow(rd_underflow),
            .data_count(data_count)
        );

        // Reference model: wq holds the edge index at which each stored word was
        // written; an FWFT head word is visible once an edge has passed after its write.
        int         wq[$];
        logic [7:0] exp_q[$];
        int         e = 0;
        logic       m_valid = 1'b0, m_ack = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
        logic [7:0] last = '0;

        always @(posedge clk or posedge rst) begin : model
            bit full, readable, racc, wacc;
            if (rst) begin
                wq.delete();
                exp_q.delete();
                e = 0;
                m_valid = 1'b0; m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
            end else begin
                e++;
                full     = (wq.size() == DEPTH);
                readable = (FW != 0) ? m_valid : (wq.size() > 0);
                racc     = rd_en && readable;
                wacc     = wr_en && !full;
                m_ovf    = wr_en && full;
                m_udf    = rd_en && !readable;
                m_ack    = (ACK != 0) && wacc;
                if (racc) void'(wq.pop_front());
                if (wacc) begin
                    wq.push_back(e);
                    exp_q.push_back(wr_data);
                end
                m_valid = (FW != 0) ? (wq.size() > 0 && wq[0] < e) : racc;
            end
        end

        always @(negedge clk) begin : monitor
            int         sz;
            logic [7:0] want;
            sz = wq.size();
            if (rst) last = '0;
            chk("data_count", g, int'(data_count), sz);
            chk("wr_full", g, int'(wr_full), int'(sz == DEPTH));
            chk("wr_almost_full", g, int'(wr_almost_full), int'(sz >= AFT));
            chk("rd_almost_empty", g, int'(rd_almost_empty), int'(sz <= AET));
            chk("rd_empty", g, int'(rd_empty), (FW != 0) ? int'(!m_valid) : int'(sz == 0));
            chk("wr_ack", g, int'(wr_ack), int'(m_ack));
            chk("wr_overflow", g, int'(wr_overflow), int'(m_ovf));
            chk("rd_underflow", g, int'(rd_underflow), int'(m_udf));
            chk("rd_valid", g, int'(rd_valid), int'(m_valid));
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underrun lane%0d: got data 0x%0h expected no output at %0t", g, rd_data, $time);
                end else begin
                    want = exp_q[0];
                    chk("rd_data", g, int'(rd_data), int'(want));
                    last = want;
                    if (FW == 0 || rd_en) void'(exp_q.pop_front());
                end
            end else begin
                chk("rd_data_idle", g, int'(rd_data), (DZ != 0) ? 0 : int'(last));
            end
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dat;
        int pw, pr;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Fill to full, overflow attempt, drain with one extra read
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 8'(i));
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'hAA);
        cyc(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 8'h00);

        // Simultaneous read/write on empty, then drain
        cyc(1'b1, 1'b1, 8'h55);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);

        // Three writes then a held read
        cyc(1'b1, 1'b0, 8'h10);
        cyc(1'b1, 1'b0, 8'h20);
        cyc(1'b1, 1'b0, 8'h30);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);

        // Reset with eight words stored, then a fresh write read back
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'($urandom));
        rst = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 8'h77);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);

        // Random traffic with phase-varying bias so the FIFO fills and empties
        dat = 0;
        for (int i = 0; i < 2000; i++) begin
            case ((i / 250) % 4)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 30; pr = 80; end
                2:       begin pw = 60; pr = 60; end
                default: begin pw = 95; pr = 95; end
            endcase
            cyc($urandom_range(99) < pw, $urandom_range(99) < pr, 8'(dat));
            dat++;
        end
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);

        chk("sb_drained", 0, lane[0].exp_q.size(), 0);
        chk("sb_drained", 1, lane[1].exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
